// File: rtl/pipeline_defs.sv
// Shared pipeline encodings: PC-source codes, fixed vector addresses, bubble instruction.
package pipeline_defs;

  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_J      = 3'b010;
  localparam logic [2:0] PCSRC_JR     = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP  = 3'b100;
  localparam logic [2:0] PCSRC_XADR   = 3'b101;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection; PC[31] is the kernel flag and is never set by
// a sequential increment, J, or a user-mode JR.
import pipeline_defs::*;

module pc_next_mux #(
  parameter logic [31:0] ILLOP_TGT = pipeline_defs::ILLOP_PC,
  parameter logic [31:0] XADR_TGT  = pipeline_defs::XADR_PC
) (
  input  logic [31:0] pc,
  input  logic [2:0]  pc_src,
  input  logic [25:0] jump_target,
  input  logic [31:0] rs_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next
);

  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  // A taken branch in EX means the ID instruction is wrong-path, so it outranks everything.
  always_comb begin
    pc_next = pc_plus4;
    if (branch_taken) begin
      pc_next = branch_target;
    end else begin
      case (pc_src)
        PCSRC_XADR:  pc_next = XADR_TGT;
        PCSRC_ILLOP: pc_next = ILLOP_TGT;
        PCSRC_JR:    pc_next = {pc[31] & rs_data[31], rs_data[30:0]};
        PCSRC_J:     pc_next = {pc[31], pc_plus4[30:28], jump_target, 2'b00};
        default:     pc_next = pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add StallCnt/FlushCnt performance counters.
import pipeline_defs::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = pipeline_defs::RESET_PC,
  parameter logic [31:0] ILLOP_PC = pipeline_defs::ILLOP_PC,
  parameter logic [31:0] XADR_PC  = pipeline_defs::XADR_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_write,
  input  logic        IF_ID_flush,
  input  logic [2:0]  ID_PCSrc,
  input  logic [25:0] ID_JumpTarget,
  input  logic [31:0] ID_RsData,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchTarget,
  input  logic [31:0] IMem_Data,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
`endif
  output logic [31:0] IMem_Addr,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  logic [31:0] pc, pc_plus4, pc_next;

  pc_next_mux #(.ILLOP_TGT(ILLOP_PC), .XADR_TGT(XADR_PC)) u_pc_next_mux (
    .pc            (pc),
    .pc_src        (ID_PCSrc),
    .jump_target   (ID_JumpTarget),
    .rs_data       (ID_RsData),
    .branch_taken  (EX_BranchTaken),
    .branch_target (EX_BranchTarget),
    .pc_plus4      (pc_plus4),
    .pc_next       (pc_next)
  );

  assign IMem_Addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pc <= RESET_PC;
    else if (PCWrite) pc <= pc_next;
  end

  // Flush beats a held register: the bubble still carries PC+4 of the squashed slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IF_ID_Inst    <= NOP_INST;
      IF_ID_PCPlus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
    end else if (IF_ID_flush) begin
      IF_ID_Inst    <= NOP_INST;
      IF_ID_PCPlus4 <= pc_plus4;
      IF_ID_Valid   <= 1'b0;
    end else if (IF_ID_write) begin
      IF_ID_Inst    <= IMem_Data;
      IF_ID_PCPlus4 <= pc_plus4;
      IF_ID_Valid   <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= 32'h0;
      FlushCnt <= 32'h0;
    end else begin
      if (!PCWrite)    StallCnt <= StallCnt + 32'd1;
      if (IF_ID_flush) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reference model of the fetch rules plus hand-computed checkpoints.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_ID_write, IF_ID_flush, EX_BranchTaken;
  logic [2:0]  ID_PCSrc;
  logic [25:0] ID_JumpTarget;
  logic [31:0] ID_RsData, EX_BranchTarget, IMem_Data;
  logic [31:0] IMem_Addr, IF_ID_Inst, IF_ID_PCPlus4;
  logic        IF_ID_Valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_PCSrc(ID_PCSrc), .ID_JumpTarget(ID_JumpTarget),
    .ID_RsData(ID_RsData), .EX_BranchTaken(EX_BranchTaken), .EX_BranchTarget(EX_BranchTarget),
    .IMem_Data(IMem_Data),
`ifdef IF_PERF_CNT_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .IMem_Addr(IMem_Addr), .IF_ID_Inst(IF_ID_Inst), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  assign IMem_Data = imem_word(IMem_Addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural PC and IF/ID contents
  logic [31:0] m_pc, m_inst, m_pp4;
  logic        m_vld;
  logic [31:0] m_stall, m_flush;

  always @(posedge clk or posedge reset) begin
    logic [31:0] seq, tgt;
    if (reset) begin
      m_pc = 32'h8000_0000; m_inst = 0; m_pp4 = 0; m_vld = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      seq = m_pc + 32'd4;
      seq[31] = m_pc[31];
      if (EX_BranchTaken)          tgt = EX_BranchTarget;
      else if (ID_PCSrc == 3'd5)   tgt = 32'h8000_0008;
      else if (ID_PCSrc == 3'd4)   tgt = 32'h8000_0004;
      else if (ID_PCSrc == 3'd3)   tgt = (ID_RsData[31] && m_pc[31]) ? ID_RsData : (ID_RsData & 32'h7FFF_FFFF);
      else if (ID_PCSrc == 3'd2)   tgt = (seq & 32'hF000_0000) | ({6'd0, ID_JumpTarget} << 2);
      else                         tgt = seq;
      if (IF_ID_flush) begin
        m_inst = 0; m_vld = 0; m_pp4 = seq;
      end else if (IF_ID_write) begin
        m_inst = imem_word(m_pc); m_vld = 1; m_pp4 = seq;
      end
      if (!PCWrite)    m_stall = m_stall + 1;
      if (IF_ID_flush) m_flush = m_flush + 1;
      if (PCWrite) m_pc = tgt;
    end
  end

  always @(negedge clk) begin
    chk("pc", IMem_Addr, m_pc);
    chk("inst", IF_ID_Inst, m_inst);
    chk("pcplus4", IF_ID_PCPlus4, m_pp4);
    chk("valid", {31'd0, IF_ID_Valid}, {31'd0, m_vld});
`ifdef IF_PERF_CNT_EN
    chk("stallcnt", StallCnt, m_stall);
    chk("flushcnt", FlushCnt, m_flush);
`endif
  end

  // Drive one cycle of inputs (called at a falling edge), then advance to the next falling edge
  task automatic cyc(input logic pcw, input logic ifw, input logic fl, input logic [2:0] src,
                     input logic [25:0] jt, input logic [31:0] rs, input logic bt, input logic [31:0] btgt);
    PCWrite = pcw; IF_ID_write = ifw; IF_ID_flush = fl; ID_PCSrc = src;
    ID_JumpTarget = jt; ID_RsData = rs; EX_BranchTaken = bt; EX_BranchTarget = btgt;
    @(negedge clk);
  endtask

  task automatic seq1();
    cyc(1, 1, 0, 3'd0, 26'd0, 32'd0, 0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    PCWrite = 1; IF_ID_write = 1; IF_ID_flush = 0; ID_PCSrc = 0;
    ID_JumpTarget = 0; ID_RsData = 0; EX_BranchTaken = 0; EX_BranchTarget = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", IMem_Addr, 32'h8000_0000);
    chk("rst_pp4", IF_ID_PCPlus4, 32'h0);
    reset = 1'b0;

    seq1(); seq1(); seq1();
    // Reset mid-cycle: outputs must change without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("midrst_pc", IMem_Addr, 32'h8000_0000);
    chk("midrst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seq1();
    chk("rel_pc1", IMem_Addr, 32'h8000_0004);
    chk("rel_inst", IF_ID_Inst, imem_word(32'h8000_0000));
    seq1();
    chk("rel_pc2", IMem_Addr, 32'h8000_0008);

    // JR from kernel to 0x10 (rs bit31 clear), then 2-cycle stall
    cyc(1, 1, 1, 3'd3, 26'd0, 32'h0000_0010, 0, 32'd0);
    chk("jr_pc", IMem_Addr, 32'h0000_0010);
    chk("jr_bubble_pp4", IF_ID_PCPlus4, 32'h8000_000C);
    seq1();
    cyc(0, 0, 0, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    chk("stall1_pc", IMem_Addr, 32'h0000_0014);
    cyc(0, 0, 0, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    chk("stall2_pc", IMem_Addr, 32'h0000_0014);
    chk("stall2_inst", IF_ID_Inst, imem_word(32'h0000_0010));
    seq1();
    chk("resume_pc", IMem_Addr, 32'h0000_0018);

    // Taken branch with flush
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 1, 32'h0000_0040);
    chk("br_pc", IMem_Addr, 32'h0000_0040);
    chk("br_inst", IF_ID_Inst, 32'h0);
    chk("br_valid", {31'd0, IF_ID_Valid}, 32'd0);
    seq1();
    chk("br_next_valid", {31'd0, IF_ID_Valid}, 32'd1);

    // User-mode JR cannot reach kernel space
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 1, 32'h0000_1000);
    cyc(1, 1, 1, 3'd3, 26'd0, 32'h8000_0100, 0, 32'd0);
    chk("jr_user", IMem_Addr, 32'h0000_0100);
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 1, 32'h8000_1000);
    cyc(1, 1, 1, 3'd3, 26'd0, 32'h8000_0100, 0, 32'd0);
    chk("jr_kernel", IMem_Addr, 32'h8000_0100);

    // Branch beats jump; interrupt, illegal-op, J
    cyc(1, 1, 1, 3'd2, 26'h3FF_FFFF, 32'd0, 1, 32'h0000_0200);
    chk("br_over_j", IMem_Addr, 32'h0000_0200);
    cyc(1, 1, 1, 3'd5, 26'd0, 32'd0, 0, 32'd0);
    chk("xadr", IMem_Addr, 32'h8000_0008);
    cyc(1, 1, 1, 3'd4, 26'd0, 32'd0, 0, 32'd0);
    chk("illop", IMem_Addr, 32'h8000_0004);
    cyc(1, 1, 1, 3'd2, 26'h000_0123, 32'd0, 0, 32'd0);
    chk("j_kernel", IMem_Addr, 32'h8000_048C);
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 1, 32'h3000_0000);
    cyc(1, 1, 1, 3'd2, 26'h000_0010, 32'd0, 0, 32'd0);
    chk("j_user_region", IMem_Addr, 32'h3000_0040);

    // Flush overrides IF_ID_write=0
    seq1();
    cyc(0, 0, 1, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    chk("flush_wins_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("flush_wins_pp4", IF_ID_PCPlus4, 32'h3000_0048);
    chk("flush_wins_pc", IMem_Addr, 32'h3000_0044);

    // Increment wraps within 31 bits, kernel flag preserved
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 1, 32'h7FFF_FFFC);
    seq1();
    chk("wrap_user", IMem_Addr, 32'h0000_0000);
    chk("wrap_user_pp4", IF_ID_PCPlus4, 32'h0000_0000);
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 1, 32'hFFFF_FFFC);
    seq1();
    chk("wrap_kernel", IMem_Addr, 32'h8000_0000);

`ifdef IF_PERF_CNT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    cyc(0, 1, 1, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    cyc(0, 0, 0, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    cyc(1, 1, 1, 3'd0, 26'd0, 32'd0, 0, 32'd0);
    seq1();
    chk("stall_cnt3", StallCnt, 32'd3);
    chk("flush_cnt2", FlushCnt, 32'd2);
`endif

    repeat (2) seq1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
